apb_slave_responder: RTL



---
 rtl/apb_resp_pkg.sv | 16 +
 rtl/apb_slave_responder_if.sv | 26 ++
 rtl/apb_resp_mem.sv | 32 +++
 rtl/apb_slave_responder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apb_resp_pkg.sv
// rtl/apb_resp_pkg.sv - shared types and CTRL layout for the APB completer model
// Purpose: FSM state type, CTRL register bit positions and wait-counter width.
package apb_resp_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int WAIT_W       = 4;
  localparam int WAIT_LSB     = 0;
  localparam int WAIT_MSB     = WAIT_LSB + WAIT_W - 1;
  localparam int ERR_INJ_BIT  = 8;
  localparam int PROT_ERR_BIT = 16;

endpackage

// File: rtl/apb_slave_responder_if.sv
// rtl/apb_slave_responder_if.sv - APB3 bus bundle for one PSEL slot
// Purpose: groups the APB transfer signals of a single completer slot.
// Ports (signals):
//   PSEL, PADDR[31:0], PENABLE, PWRITE, PWDATA[31:0]  initiator -> completer
//   PRDATA[31:0], PREADY, PSLVERR                      completer -> initiator
// Modports: master (initiator side), slave (completer side).
interface apb_slave_responder_if;
  logic        PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_resp_mem.sv
// rtl/apb_resp_mem.sv - word memory backing the completer slot
// Purpose: (2^IW - 1) x 32 register array, synchronous write, asynchronous read.
// Ports:
//   clk        write clock
//   we_i       write enable
//   waddr_i    write word index
//   wdata_i    write data
//   raddr_i    read word index
//   rdata_o    read data (0 for the unbacked top index)
module apb_resp_mem #(
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  // The top index belongs to CTRL, so the array stops one word short.
  localparam int WORDS = (1 << IW) - 1;

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < WORDS) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/apb_slave_responder.sv
// rtl/apb_slave_responder.sv - APB3 completer with memory, CTRL, wait states and error injection
// Purpose: answers APB transfers on one PSEL slot; programmable wait states,
//   one-shot error injection and a sticky initiator protocol-violation flag.
// Ports:
//   PCLK      clock, rising edge
//   PRESET    asynchronous active-high reset
//   apb       APB slave modport (PSEL/PADDR/PENABLE/PWRITE/PWDATA in,
//             PRDATA/PREADY/PSLVERR out)
//   PROT_ERR  sticky protocol-violation flag (mirrors CTRL[16])
module apb_slave_responder
  import apb_resp_pkg::*;
#(
  parameter int AWIDTH       = 10,
  parameter int DEFAULT_WAIT = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_slave_responder_if.slave  apb,
  output logic                  PROT_ERR
);
  localparam int IW = AWIDTH - 2;
  localparam logic [IW-1:0] CTRL_IDX = '1;

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              write_q;
  logic              err_q;
  logic              err_inj_q;
  logic              prot_err_q;

  logic [IW-1:0] setup_idx;
  logic [IW-1:0] acc_idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   ctrl_rdata;
  logic [31:0]   rdata_d;
  logic          err_d;
  logic          in_access;
  logic          pready;
  logic          do_setup;
  logic          violation;
  logic          complete;
  logic          mem_we;
  logic          ctrl_we;
  logic          idle_bad_enable;

  assign setup_idx = apb.PADDR[AWIDTH-1:2];
  assign acc_idx   = addr_q[AWIDTH-1:2];

  apb_resp_mem #(.IW(IW)) u_mem (
    .clk     (PCLK),
    .we_i    (mem_we),
    .waddr_i (acc_idx),
    .wdata_i (wdata_q),
    .raddr_i (setup_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    ctrl_rdata                    = '0;
    ctrl_rdata[WAIT_MSB:WAIT_LSB] = wait_q;
    ctrl_rdata[ERR_INJ_BIT]       = err_inj_q;
    ctrl_rdata[PROT_ERR_BIT]      = prot_err_q;
  end

  // Error status and read data are resolved at the setup edge.
  assign err_d = (|apb.PADDR[31:AWIDTH]) | (|apb.PADDR[1:0]) | err_inj_q;

  always_comb begin
    rdata_d = '0;
    if (!err_d) begin
      rdata_d = (setup_idx == CTRL_IDX) ? ctrl_rdata : mem_rdata;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign pready    = in_access && (cnt_q == '0);

  // Any deviation from the latched transfer while in ACCESS aborts it.
  assign violation = in_access &&
                     (!apb.PSEL || !apb.PENABLE ||
                      (apb.PADDR != addr_q) || (apb.PWRITE != write_q) ||
                      (apb.PWDATA != wdata_q));

  assign complete        = pready && !violation;
  assign idle_bad_enable = (state_q == ST_IDLE) && apb.PSEL && apb.PENABLE;

  // PSEL with PENABLE low is a setup phase in either state; in ACCESS it is
  // also a violation, so the old transfer aborts and the new one is taken.
  assign do_setup = apb.PSEL && !apb.PENABLE;

  assign mem_we  = complete && write_q && !err_q && (acc_idx != CTRL_IDX);
  assign ctrl_we = complete && write_q && !err_q && (acc_idx == CTRL_IDX);

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pready && err_q;
  assign apb.PRDATA  = (pready && !write_q && !err_q) ? rdata_q : '0;
  assign PROT_ERR    = prot_err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= WAIT_W'(DEFAULT_WAIT);
      err_inj_q  <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      if (do_setup) begin
        state_q <= ST_ACCESS;
        addr_q  <= apb.PADDR;
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
        rdata_q <= rdata_d;
        err_q   <= err_d;
        cnt_q   <= wait_q;
      end else if (complete || violation) begin
        state_q <= ST_IDLE;
      end else if (in_access) begin
        cnt_q <= cnt_q - WAIT_W'(1);
      end

      // A CTRL write that re-arms ERR_INJ wins over the completion clear.
      if (complete) begin
        err_inj_q <= 1'b0;
      end
      if (ctrl_we) begin
        wait_q    <= wdata_q[WAIT_MSB:WAIT_LSB];
        err_inj_q <= wdata_q[ERR_INJ_BIT];
      end

      if (idle_bad_enable || violation) begin
        prot_err_q <= 1'b1;
      end else if (ctrl_we && wdata_q[PROT_ERR_BIT]) begin
        prot_err_q <= 1'b0;
      end
    end
  end
endmodule
